// File: rtl/fwd_select_ctrl.sv
// fwd_select_ctrl
//   Produces registered operand-source selects for the EX-stage operand muxes
//   (00 = register file, 01 = EX/MEM result, 10 = MEM/WB result) and detects
//   load-use hazards, raising a combinational stall toward IF/ID.
//   Steps in lockstep with the ID/EX pipeline register.
//
// Ports
//   clk, rst                    pipeline clock, synchronous active-high reset
//   id_valid                    ID holds a real instruction
//   id_rs1/id_rs2, *_used       source registers in ID and whether each is read
//   id_rd, id_reg_write         destination register and write enable in ID
//   id_mem_read                 ID instruction is a load
//   hold_in                     global pipeline freeze
//   flush                       kill the ID instruction
//   fwd_a_sel, fwd_b_sel        registered selects for the instruction in EX
//   ex_valid                    EX slot holds a real instruction
//   stall_id                    hold PC and IF/ID this cycle
//   stall_cnt                   saturating count of load-use stall cycles
module fwd_select_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              hold_in,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              ex_valid,
  output logic              stall_id,
  output logic [CNT_W-1:0]  stall_cnt
);

  // EX tag (valid is the ex_valid output) and MEM tag. A load's MEM-stage
  // identity is irrelevant to forwarding, so MEM carries no load flag.
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wr;
  logic              ex_load;
  logic              mem_valid;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_wr;

  logic       load_use;
  logic       issue;
  logic [1:0] sel_a_next;
  logic [1:0] sel_b_next;

  function automatic logic [1:0] pick_src(
    input logic [REG_AW-1:0] rs,
    input logic              used,
    input logic              e_valid,
    input logic              e_wr,
    input logic [REG_AW-1:0] e_rd,
    input logic              m_valid,
    input logic              m_wr,
    input logic [REG_AW-1:0] m_rd
  );
    logic [1:0] src;
    src = 2'b00;
    if (used && (rs != '0)) begin
      // nearer producer wins
      if (e_valid && e_wr && (e_rd == rs))
        src = 2'b01;
      else if (m_valid && m_wr && (m_rd == rs))
        src = 2'b10;
    end
    return src;
  endfunction

  always_comb begin
    load_use = ex_valid && ex_load && ex_wr && (ex_rd != '0) && id_valid &&
               ((id_rs1_used && (id_rs1 == ex_rd)) ||
                (id_rs2_used && (id_rs2 == ex_rd)));
    stall_id = load_use && !flush && !hold_in && !rst;
    issue    = id_valid && !flush && !stall_id;

    // A load in EX that matches always stalls, so it never leaves a 01 here.
    sel_a_next = 2'b00;
    sel_b_next = 2'b00;
    if (issue) begin
      sel_a_next = pick_src(id_rs1, id_rs1_used, ex_valid, ex_wr, ex_rd,
                            mem_valid, mem_wr, mem_rd);
      sel_b_next = pick_src(id_rs2, id_rs2_used, ex_valid, ex_wr, ex_rd,
                            mem_valid, mem_wr, mem_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_wr     <= 1'b0;
      ex_load   <= 1'b0;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_wr    <= 1'b0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
      stall_cnt <= '0;
    end else if (!hold_in) begin
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_wr    <= ex_wr;
      ex_valid  <= issue;
      ex_rd     <= id_rd;
      ex_wr     <= id_reg_write;
      ex_load   <= id_mem_read;
      fwd_a_sel <= sel_a_next;
      fwd_b_sel <= sel_b_next;
      if (stall_id && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
